// File: rtl/filtro_pkg.sv
// Shared widths, sample/accumulator types and the fixed coefficient set of the filter.
// Default coefficients give y[n] = x[n] + 0.5*x[n-1].
package filtro_pkg;
  localparam int W_DEF    = 16;
  localparam int FRAC_DEF = 8;
  localparam int TAPS_MAX = 16;

  typedef logic signed [W_DEF-1:0]     sample_t;
  typedef logic signed [2*W_DEF+3:0]   acc_t;

  // Q8.8 coefficients: tap 0 = 1.0, tap 1 = 0.5.
  localparam sample_t COEF [0:TAPS_MAX-1] = '{
    16'sh0100, 16'sh0080, 16'sh0000, 16'sh0000,
    16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000,
    16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000,
    16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000
  };
endpackage

// File: rtl/filtro_datapath_if.sv
// Strobe/sample bus between the cntrl sequencer (master) and the filter datapath (slave).
// No backpressure: every strobe is acted on in the cycle it is seen.
interface filtro_datapath_if #(parameter int W = 16);
  logic signed [W-1:0] u_in;
  logic                leer_u;
  logic                desp;
  logic [3:0]          sel;
  logic                leer;
  logic                rst_acum;
  logic                leer_y;
  logic signed [W-1:0] y;
  logic                y_valid;
  logic                sat;

  modport master (
    output u_in, leer_u, desp, sel, leer, rst_acum, leer_y,
    input  y, y_valid, sat
  );

  modport slave (
    input  u_in, leer_u, desp, sel, leer, rst_acum, leer_y,
    output y, y_valid, sat
  );
endinterface

// File: rtl/coef_rom.sv
// Combinational coefficient lookup by tap index; taps beyond TAPS read as zero.
// Zero latency, no backpressure.
module coef_rom
  import filtro_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int TAPS = TAPS_MAX
) (
  input  logic [3:0]          sel,
  output logic signed [W-1:0] coef
);

  always_comb begin
    coef = '0;
    if (32'(sel) < TAPS) coef = W'(COEF[sel]);
  end

endmodule

// File: rtl/filtro_datapath.sv
// Filter datapath: input register, tapped delay line, one-tap-per-cycle MAC, saturated output.
// leer_y -> y/y_valid one cycle later; no backpressure, all ordering comes from cntrl.
module filtro_datapath
  import filtro_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int TAPS = TAPS_MAX
) (
  input  logic               clk,
  input  logic               rst,
  filtro_datapath_if.slave   bus
);

  localparam int ACC_W = 2*W + 4;
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'({1'b0, {(W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  logic signed [W-1:0]     u_q, u_d;
  logic signed [W-1:0]     x_q [TAPS];
  logic signed [W-1:0]     x_d [TAPS];
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [W-1:0]     y_q, y_d;
  logic                    y_valid_q, y_valid_d;
  logic                    sat_q, sat_d;

  logic signed [W-1:0]     coef;
  logic signed [W-1:0]     x_sel;
  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_s;

  coef_rom #(.W(W), .TAPS(TAPS)) u_coef_rom (
    .sel  (bus.sel),
    .coef (coef)
  );

  // Out-of-range taps select zero, so the product vanishes for sel >= TAPS.
  always_comb begin
    x_sel = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (32'(bus.sel) == i) x_sel = x_q[i];
    end
  end

  assign prod     = (2*W)'(coef) * (2*W)'(x_sel);
  assign prod_ext = ACC_W'(prod);
  assign acc_s    = acc_q >>> FRAC;

  always_comb begin
    u_d = bus.leer_u ? bus.u_in : u_q;
    x_d = x_q;
    if (bus.desp) begin
      x_d[0] = u_q;
      for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (bus.rst_acum && bus.leer) acc_d = prod_ext;
    else if (bus.rst_acum)        acc_d = '0;
    else if (bus.leer)            acc_d = acc_q + prod_ext;
  end

  // Output stage reads the accumulator as it stands before this cycle's update.
  always_comb begin
    y_d       = y_q;
    sat_d     = sat_q;
    y_valid_d = bus.leer_y;
    if (bus.leer_y) begin
      if (acc_s > Y_MAX) begin
        y_d   = {1'b0, {(W-1){1'b1}}};
        sat_d = 1'b1;
      end else if (acc_s < Y_MIN) begin
        y_d   = {1'b1, {(W-1){1'b0}}};
        sat_d = 1'b1;
      end else begin
        y_d = acc_s[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_q       <= '0;
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      u_q       <= u_d;
      x_q       <= x_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      sat_q     <= sat_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.sat     = sat_q;

endmodule

// File: tb/tb_filtro_datapath.sv
// Self-checking bench: a TAPS=16 and a TAPS=1 datapath share one strobe stream.
// Directed vector table, hand-written corner sequences and random frames against a frame-level model.
module tb_filtro_datapath;

  logic clk;
  logic rst;

  filtro_datapath_if #(.W(16)) bus  ();
  filtro_datapath_if #(.W(16)) bus1 ();

  assign bus1.u_in     = bus.u_in;
  assign bus1.leer_u   = bus.leer_u;
  assign bus1.desp     = bus.desp;
  assign bus1.sel      = bus.sel;
  assign bus1.leer     = bus.leer;
  assign bus1.rst_acum = bus.rst_acum;
  assign bus1.leer_y   = bus.leer_y;

  filtro_datapath #(.W(16), .FRAC(8), .TAPS(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  filtro_datapath #(.W(16), .FRAC(8), .TAPS(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Frame-level reference: sample history (newest first) and the coefficient values.
  int          hist   [16];
  int          coef_m [16];
  bit          sat_m;
  logic [15:0] m_y;

  typedef struct {
    logic [15:0] u;
    logic [15:0] ey;
    logic        esat;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    bus.leer_u   = 1'b0;
    bus.desp     = 1'b0;
    bus.leer     = 1'b0;
    bus.rst_acum = 1'b0;
    bus.leer_y   = 1'b0;
    bus.sel      = 4'd0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) hist[i] = 0;
    sat_m = 1'b0;
  endtask

  task automatic model_push(input logic [15:0] u);
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'($signed(u));
  endtask

  // y = floor(sum(coef*x) / 256), clamped to 16-bit signed; sat is sticky.
  task automatic model_out(output logic [15:0] ey);
    longint s;
    s = 0;
    for (int i = 0; i < 16; i++) s += longint'(coef_m[i]) * longint'(hist[i]);
    s = s >>> 8;
    if (s > 32767) begin
      ey = 16'h7FFF; sat_m = 1'b1;
    end else if (s < -32768) begin
      ey = 16'h8000; sat_m = 1'b1;
    end else begin
      ey = 16'(s);
    end
  endtask

  // One full cntrl frame; returns with the new output visible.
  task automatic frame(input logic [15:0] u);
    @(negedge clk); clr(); bus.leer_u = 1'b1; bus.u_in = u;
    @(negedge clk); clr(); bus.desp = 1'b1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk); clr();
      bus.leer = 1'b1; bus.sel = 4'(t); bus.rst_acum = (t == 0);
    end
    @(negedge clk); clr(); bus.leer_y = 1'b1;
    @(negedge clk); clr();
    model_push(u);
    model_out(m_y);
  endtask

  task automatic check_out(input string nm, input logic [15:0] ey, input logic esat,
                           input logic [15:0] ey1);
    chk({nm, ".y"},     bus.y,        ey);
    chk({nm, ".vld"},   {15'd0, bus.y_valid}, 16'd1);
    chk({nm, ".sat"},   {15'd0, bus.sat},     {15'd0, esat});
    chk({nm, ".y1"},    bus1.y,       ey1);
    @(negedge clk);
    chk({nm, ".vld_drop"}, {15'd0, bus.y_valid}, 16'd0);
  endtask

  initial begin
    logic [15:0] u;
    logic        seen_vld;

    for (int i = 0; i < 16; i++) coef_m[i] = 0;
    coef_m[0] = 256;
    coef_m[1] = 128;
    model_reset();

    tbl[0]  = '{16'h0100, 16'h0100, 1'b0};
    tbl[1]  = '{16'h0000, 16'h0080, 1'b0};
    tbl[2]  = '{16'h0000, 16'h0000, 1'b0};
    tbl[3]  = '{16'h7FFF, 16'h7FFF, 1'b0};
    tbl[4]  = '{16'h7FFF, 16'h7FFF, 1'b1};
    tbl[5]  = '{16'h0000, 16'h3FFF, 1'b1};
    tbl[6]  = '{16'h0000, 16'h0000, 1'b1};
    tbl[7]  = '{16'h8000, 16'h8000, 1'b1};
    tbl[8]  = '{16'h8000, 16'h8000, 1'b1};
    tbl[9]  = '{16'h0000, 16'hC000, 1'b1};
    tbl[10] = '{16'h0000, 16'h0000, 1'b1};

    // Reset held with random strobes.
    rst = 1'b0;
    bus.u_in = '0;
    clr();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.u_in     = 16'($urandom);
      bus.leer_u   = 1'($urandom);
      bus.desp     = 1'($urandom);
      bus.leer     = 1'($urandom);
      bus.rst_acum = 1'($urandom);
      bus.leer_y   = 1'($urandom);
      bus.sel      = 4'($urandom);
    end
    chk("rst.y",   bus.y, 16'd0);
    chk("rst.vld", {15'd0, bus.y_valid}, 16'd0);
    chk("rst.sat", {15'd0, bus.sat}, 16'd0);
    @(negedge clk); clr(); rst = 1'b1;

    // First leer_y with nothing accumulated.
    @(negedge clk); bus.leer_y = 1'b1;
    @(negedge clk); clr();
    chk("first.y",   bus.y, 16'd0);
    chk("first.vld", {15'd0, bus.y_valid}, 16'd1);
    @(negedge clk);
    chk("first.vld_drop", {15'd0, bus.y_valid}, 16'd0);

    // Impulse and saturation table; TAPS=1 instance just passes the sample.
    for (int k = 0; k < 11; k++) begin
      frame(tbl[k].u);
      check_out($sformatf("tbl%0d", k), tbl[k].ey, tbl[k].esat, tbl[k].u);
    end

    // rst_acum+leer restarts the sum; sel beyond TAPS contributes nothing.
    frame(16'd200);
    frame(16'd100);
    check_out("pre_acc", m_y, sat_m, 16'd100);
    @(negedge clk); bus.leer = 1'b1; bus.sel = 4'd0; bus.rst_acum = 1'b1;
    @(negedge clk); clr(); bus.leer = 1'b1; bus.sel = 4'd0;
    @(negedge clk); clr(); bus.leer = 1'b1; bus.sel = 4'd0; bus.rst_acum = 1'b1;
    @(negedge clk); clr(); bus.leer_y = 1'b1;
    @(negedge clk); clr();
    chk("restart.y",  bus.y,  16'd100);
    chk("restart.y1", bus1.y, 16'd100);
    @(negedge clk); bus.leer = 1'b1; bus.sel = 4'd0; bus.rst_acum = 1'b1;
    @(negedge clk); clr(); bus.leer = 1'b1; bus.sel = 4'd1;
    @(negedge clk); clr(); bus.leer = 1'b1; bus.sel = 4'd15;
    @(negedge clk); clr(); bus.leer_y = 1'b1;
    @(negedge clk); clr();
    chk("seltaps.y",  bus.y,  16'd200);
    chk("seltaps.y1", bus1.y, 16'd100);

    // Same-cycle leer_u + desp: tap 0 takes the old input register.
    @(negedge clk); clr(); bus.leer_u = 1'b1; bus.u_in = 16'd5;
    @(negedge clk); clr(); bus.leer_u = 1'b1; bus.u_in = 16'd9; bus.desp = 1'b1;
    @(negedge clk); clr(); bus.leer = 1'b1; bus.rst_acum = 1'b1;
    @(negedge clk); clr(); bus.leer_y = 1'b1;
    @(negedge clk); clr();
    chk("samecyc.x0", bus.y, 16'd5);
    bus.desp = 1'b1;
    @(negedge clk); clr(); bus.leer = 1'b1; bus.rst_acum = 1'b1;
    @(negedge clk); clr(); bus.leer_y = 1'b1;
    @(negedge clk); clr();
    chk("samecyc.ur", bus.y, 16'd9);
    model_push(16'd5);
    model_push(16'd9);

    // Reset in the middle of a sum.
    @(negedge clk); clr(); bus.leer_u = 1'b1; bus.u_in = 16'h0300;
    @(negedge clk); clr(); bus.desp = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); clr(); bus.leer = 1'b1; bus.sel = 4'(t); bus.rst_acum = (t == 0);
    end
    @(negedge clk); clr(); rst = 1'b0;
    #1;
    chk("midrst.y",   bus.y, 16'd0);
    chk("midrst.sat", {15'd0, bus.sat}, 16'd0);
    seen_vld = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen_vld = seen_vld | bus.y_valid;
    end
    chk("midrst.novld", {15'd0, seen_vld}, 16'd0);
    model_reset();
    frame(16'h0200);
    check_out("postrst", 16'h0200, 1'b0, 16'h0200);

    // Random frames against the reference model.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 0) u = 16'($urandom_range(0, 4095)) - 16'd2048;
      else                            u = 16'($urandom);
      frame(u);
      check_out($sformatf("rnd%0d", k), m_y, sat_m, u);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/filtro_datapath.md
# filtro_datapath

Arithmetic datapath of the digital filter, placed directly downstream of the `cntrl` sequencer. It consumes `cntrl`'s strobes (`leer`, `desp`, `leer_y`, `rst_acum`, `leer_u`, `sel`) to do four things: capture input samples, shift a tapped delay line, multiply-accumulate one tap per cycle against a fixed coefficient set, and publish a saturated filter output. It makes no sequencing decisions of its own; all ordering comes from `cntrl`.

## Interface

Parameters:

- `W`, 16: sample, coefficient and output width (signed two's complement).
- `FRAC`, 8: fractional bits of coefficients (Q(W-FRAC).FRAC).
- `TAPS`, 16: number of delay-line taps, 1..16.

Ports:

- `clk` input 1: single clock; all state rising-edge.
- `rst` input 1: reset, asynchronous assert, active-low.
- `u_in` input W: new input sample.
- `leer_u` input 1: capture `u_in` into input register.
- `desp` input 1: shift delay line one position; input register enters tap 0.
- `sel` input 4: tap index for current MAC cycle.
- `leer` input 1: accumulate product `coef[sel]*x[sel]`.
- `rst_acum` input 1: clear accumulator.
- `leer_y` input 1: latch accumulator to output.
- `y` output W: filter output, scaled and saturated.
- `y_valid` output 1: one-cycle pulse when `y` updates.
- `sat` output 1: sticky flag; set when any latched output saturated.

## Operation

- Input register `u_r` (W bits): on `leer_u`, `u_r <= u_in`.
- Delay line `x[0..TAPS-1]`: on `desp`, `x[0] <= u_r` and `x[i] <= x[i-1]`.
- If `desp` and `leer_u` occur in the same cycle, tap 0 receives the old `u_r`.
- Product `p = coef[sel] * x[sel]`, full 2W signed bits.
- If `sel >= TAPS`, `p = 0`.
- Accumulator `acc` is 2W+4 bits signed; the 4 guard bits cover 16 taps with no wrap.
- Accumulator update per cycle, in priority order:
  - `rst_acum && leer`: `acc <= p` (start a new sum).
  - `rst_acum` only: `acc <= 0`.
  - `leer` only: `acc <= acc + p`.
  - otherwise hold.
- On `leer_y`, the pre-update `acc` is used (value present in the register that cycle):
  - `s = acc >>> FRAC`, arithmetic shift, truncation toward −∞.
  - If `s > 2^(W-1)-1`, then `y <= 2^(W-1)-1` and `sat <= 1`.
  - If `s < -2^(W-1)`, then `y <= -2^(W-1)` and `sat <= 1`.
  - Otherwise `y <= s[W-1:0]`.
- `y_valid` is asserted the cycle after `leer_y`, for exactly one cycle.
- `sat` clears only on reset.
- Reset (`rst` = 0, asynchronous): `u_r`, all `x[i]`, `acc`, `y`, `y_valid` and `sat` go to 0.
  - Reset mid-sum discards the partial sum; no `y_valid` is produced for it.

## Timing

- `leer_u` → `u_r`: 1 cycle. `desp` → new tap 0: 1 cycle.
- `leer` with `sel` → product included in `acc`: 1 cycle, no pipelining. Strobes are sampled on the same edge as `sel`.
- Last `leer` at cycle n requires `leer_y` no earlier than cycle n+1 for that product to be included.
- `leer_y` at cycle n → `y` and `y_valid` valid at cycle n+1.
- Back-to-back `leer_y` is allowed; each produces a pulse.
- One full output per `cntrl` frame: `leer_u`, `desp`, then TAPS `leer` cycles (the first with `rst_acum`), then `leer_y`. This takes TAPS+3 cycles minimum.

## Structure

- Package `filtro_pkg` holds:
  - `W_DEF`, `FRAC_DEF`, `TAPS_MAX` = 16.
  - `sample_t` and `acc_t` typedefs.
  - coefficient array `COEF[0:15]`. Default set: `COEF[0]=16'h0100` (1.0), `COEF[1]=16'h0080` (0.5), the rest 0.
- Sub-module `coef_rom`: combinational lookup `sel` → `COEF[sel]` (returns 0 for `sel >= TAPS`).
- Delay line, MAC and output stage stay in `filtro_datapath`.

## Test plan

- Reset: hold `rst` = 0 with random strobes → `y` = 0, `y_valid` = 0, `sat` = 0. Release; first `leer_y` with no accumulation → `y` = 0, `y_valid` pulses.
- Impulse, default coefficients:
  - Frame 1: `u_in` = 16'h0100, full frame → `y` = 16'h0100.
  - Frame 2: `u_in` = 0 → `y` = 16'h0080.
  - Frame 3: `u_in` = 0 → `y` = 0.
- Same-cycle `leer_u` + `desp`: `u_r` = 5, `u_in` = 9 → `x[0]` = 5 and `u_r` = 9 after the edge.
- Saturation: after two frames of `u_in` = 16'h7FFF, next output → `y` = 16'h7FFF and `sat` = 1; `sat` stays 1 through later in-range outputs.
- Same for 16'h8000: `y` = 16'h8000.
- `rst_acum` + `leer` same cycle with `acc` = 1000 → `acc` = p, not 1000 + p. A `sel` of 15 with `TAPS` = 2 → product 0.
- Reset asserted mid-accumulation (after 3 `leer` cycles) → `acc` = 0, no `y_valid`; the next frame produces the correct `y`.
